uart_rx_fifo: RTL and testbench

- Receive-side buffer sitting directly downstream of the UART receiver, in the clk16x domain.
- Detects the receiver's r_ready and issues a one-cycle active-low read strobe to it.
- Captures the data byte plus its parity and frame error flags into a circular FIFO.
- Presents the oldest entry to the CPU, so bytes are not lost while the CPU is slow to poll.

---
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer for the UART receiver. It drains each received frame
// with a one-cycle active-low read strobe and stores the byte together with its
// parity and frame error flags in a circular FIFO. The oldest entry is shown
// to the CPU.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int HOLDOFF    = 4
) (
    input  logic                  clk16x,
    input  logic                  clrn,
    input  logic                  r_ready,
    input  logic [7:0]            d_in,
    input  logic                  parity_error_in,
    input  logic                  frame_error_in,
    output logic                  rdn_rx,
    input  logic                  cpu_rd,
    output logic [7:0]            q,
    output logic                  q_perr,
    output logic                  q_ferr,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int GW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [GW-1:0]       GUARD_LOAD = GW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [GW-1:0]         guard, guard_next;
    logic                  rdn_next;
    logic                  snap_load;
    logic                  perr_snap, ferr_snap;
    logic                  push, pop, wr_en, drop;
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [9:0]            mem [DEPTH];

    // Handshake sequencing: accept a ready frame, strobe for one cycle, then ignore ready for HOLDOFF cycles
    always_comb begin
        state_next = state;
        guard_next = guard;
        rdn_next   = 1'b1;
        snap_load  = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (r_ready) begin
                    snap_load  = 1'b1;
                    rdn_next   = 1'b0;
                    state_next = READ;
                end
            end
            READ: begin
                push       = 1'b1;
                guard_next = GUARD_LOAD;
                state_next = GUARD;
            end
            GUARD: begin
                if (guard == '0) begin
                    state_next = IDLE;
                end else begin
                    guard_next = guard - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, read strobe and error-flag snapshot registers
    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            guard     <= '0;
            rdn_rx    <= 1'b1;
            perr_snap <= 1'b0;
            ferr_snap <= 1'b0;
        end else begin
            state  <= state_next;
            guard  <= guard_next;
            rdn_rx <= rdn_next;
            // The receiver clears its flags as soon as rdn falls, so they are captured on the accepting edge
            if (snap_load) begin
                perr_snap <= parity_error_in;
                ferr_snap <= frame_error_in;
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = cpu_rd & ~empty;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // Pointer, occupancy and sticky overrun bookkeeping
    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // Entry storage; deliberately not reset
    always_ff @(posedge clk16x) begin
        if (wr_en) begin
            mem[wptr] <= {d_in, perr_snap, ferr_snap};
        end
    end

    // Show-ahead head entry, forced to zero while empty
    always_comb begin
        q      = '0;
        q_perr = 1'b0;
        q_ferr = 1'b0;
        if (!empty) begin
            {q, q_perr, q_ferr} = mem[rptr];
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based model predicts the
// strobe timing, occupancy, head entry and overrun on every cycle, and
// directed literal checks pin the model for each scenario.
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int HOLDOFF    = 4;

    logic                clk16x = 1'b0;
    logic                clrn = 1'b0;
    logic                r_ready = 1'b0;
    logic [7:0]          d_in = 8'h00;
    logic                parity_error_in = 1'b0;
    logic                frame_error_in = 1'b0;
    logic                rdn_rx;
    logic                cpu_rd = 1'b0;
    logic [7:0]          q;
    logic                q_perr, q_ferr, empty, full, overrun;
    logic [DEPTH_LOG2:0] count;
    logic                clr_overrun = 1'b0;

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .HOLDOFF(HOLDOFF)) dut (
        .clk16x(clk16x), .clrn(clrn), .r_ready(r_ready), .d_in(d_in),
        .parity_error_in(parity_error_in), .frame_error_in(frame_error_in),
        .rdn_rx(rdn_rx), .cpu_rd(cpu_rd), .q(q), .q_perr(q_perr), .q_ferr(q_ferr),
        .empty(empty), .full(full), .count(count), .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk16x = ~clk16x;

    int errors = 0;
    int checks = 0;

    // Model state: entries are {data, perr, ferr}
    logic [9:0] mq[$];
    logic       m_ovr;
    logic       m_rdn;
    logic       m_pend;
    logic [1:0] m_snap;
    int         m_edge;
    int         m_accept_at;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr       = 1'b0;
        m_rdn       = 1'b1;
        m_pend      = 1'b0;
        m_snap      = 2'b00;
        m_accept_at = 0;
    endtask

    // Applies the behavioural rules for one rising edge using the bench's own stimulus
    task automatic model_edge();
        logic did_pop, dropped;
        m_edge++;
        if (!clrn) begin
            model_reset();
            return;
        end
        did_pop = cpu_rd && (mq.size() > 0);
        dropped = 1'b0;
        if (m_pend) begin
            if (mq.size() < DEPTH || did_pop) begin
                if (did_pop) void'(mq.pop_front());
                mq.push_back({d_in, m_snap});
                did_pop = 1'b0;
            end else begin
                dropped = 1'b1;
            end
            m_pend      = 1'b0;
            m_rdn       = 1'b1;
            m_accept_at = m_edge + 1 + HOLDOFF;
        end else if (r_ready && m_edge >= m_accept_at) begin
            m_pend = 1'b1;
            m_snap = {parity_error_in, frame_error_in};
            m_rdn  = 1'b0;
        end
        if (did_pop) void'(mq.pop_front());
        if (dropped) m_ovr = 1'b1;
        else if (clr_overrun) m_ovr = 1'b0;
    endtask

    task automatic compare_all();
        logic [9:0] h;
        h = (mq.size() > 0) ? mq[0] : 10'h000;
        chk("rdn_rx", rdn_rx, m_rdn);
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("q", q, h[9:2]);
        chk("q_perr", q_perr, h[1]);
        chk("q_ferr", q_ferr, h[0]);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic step();
        @(posedge clk16x);
        model_edge();
        @(negedge clk16x);
        compare_all();
    endtask

    // One receiver frame; hold keeps r_ready high for that many cycles after the strobe edge
    task automatic frame(input logic [7:0] data, input logic pe, input logic fe,
                         input int hold, input logic pop_rd, input logic clr_rd);
        r_ready = 1'b1; d_in = data; parity_error_in = pe; frame_error_in = fe;
        step();
        // receiver drops its flags once the strobe is seen low
        parity_error_in = 1'b0; frame_error_in = 1'b0;
        r_ready = (hold > 0); cpu_rd = pop_rd; clr_overrun = clr_rd;
        step();
        cpu_rd = 1'b0; clr_overrun = 1'b0; d_in = 8'h00;
        for (int i = 0; i < HOLDOFF; i++) begin
            r_ready = (i + 1 < hold);
            step();
        end
        r_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (mq.size() > 0) begin
                cpu_rd = 1'b1;
                step();
                cpu_rd = 1'b0;
            end
        end
    endtask

    initial begin
        m_edge = 0;
        model_reset();
        step();
        step();
        chk("reset_rdn", rdn_rx, 1'b1);
        chk("reset_empty", empty, 1'b1);
        chk("reset_count", count, 0);
        chk("reset_q", q, 8'h00);
        clrn = 1'b1;
        step();

        // Single frame
        frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("single_count", count, 1);
        chk("single_q", q, 8'hA5);
        chk("single_flags", {q_perr, q_ferr}, 2'b00);
        drain();

        // Error flags captured before the receiver clears them
        frame(8'h3C, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        chk("err_flags", {q_perr, q_ferr}, 2'b11);
        chk("err_q", q, 8'h3C);
        drain();

        // Ready held high after the strobe yields a single push
        frame(8'h5A, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        chk("rearm_count", count, 1);
        drain();

        // Fill to full, then overrun on the ninth byte
        for (int i = 1; i <= DEPTH + 1; i++) begin
            frame(8'(i), 1'b0, 1'b0, 0, 1'b0, 1'b0);
            if (i == DEPTH) chk("fill_full", full, 1'b1);
        end
        chk("fill_overrun", overrun, 1'b1);
        chk("fill_count", count, DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("pop_order", q, i);
            cpu_rd = 1'b1;
            step();
            cpu_rd = 1'b0;
        end
        chk("drained_empty", empty, 1'b1);
        chk("drained_q", q, 8'h00);
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        chk("empty_pop_count", count, 0);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // Full with a pop coinciding with the write, then set-versus-clear
        for (int i = 0; i < DEPTH; i++) frame(8'h11 + 8'(i), 1'b0, 1'b0, 0, 1'b0, 1'b0);
        frame(8'h20, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("concur_count", count, DEPTH);
        chk("concur_overrun", overrun, 1'b0);
        chk("concur_head", q, 8'h12);
        frame(8'h21, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("set_wins", overrun, 1'b1);

        // Reset while the strobe is low
        r_ready = 1'b1; d_in = 8'h99;
        step();
        chk("pre_reset_rdn", rdn_rx, 1'b0);
        #2 clrn = 1'b0;
        #1;
        model_reset();
        chk("mid_reset_rdn", rdn_rx, 1'b1);
        chk("mid_reset_count", count, 0);
        chk("mid_reset_empty", empty, 1'b1);
        chk("mid_reset_ovr", overrun, 1'b0);
        r_ready = 1'b0; d_in = 8'h00;
        @(negedge clk16x);
        step();
        clrn = 1'b1;
        step();
        frame(8'h77, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("post_reset_q", q, 8'h77);
        chk("post_reset_ferr", q_ferr, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
